alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Execute-stage ALU sequencer: the next generation of the ALU control block.
- Decodes the control opcode and operation select into an ALU opcode and selects operands.
- Computes single-cycle ops in 1 cycle. Shifts run iteratively, SHIFT_STEP bits per cycle.
- Uses a ready/valid handshake with flush, so the pipeline can stall on long shifts.

Parameters:
NB_DATA, 32, operand/result width
NB_ADDR, $clog2(NB_DATA), shift-amount width
NB_CTRL_OPCODE, 6, control opcode width
NB_ALU_OPCODE, 4, internal ALU opcode width
NB_ALU_OP_SEL, 2, operation-select width
SHIFT_STEP, 1, bits shifted per cycle in SHIFT state (1..NB_DATA-1)

Ports:
i_clock  in  1  clock, all logic on rising edge
i_reset  in  1  synchronous reset, active-low
i_valid  in  1  request valid
o_ready  out  1  block accepts a request this cycle
i_ctrl_opcode  in  NB_CTRL_OPCODE  control opcode; low NB_ALU_OPCODE bits carry the ALU op
i_operation  in  NB_ALU_OP_SEL  00/11 R/I-type, 01 load/store, 10 branch
i_data_a  in  NB_DATA  rs operand
i_data_b  in  NB_DATA  rt/immediate operand
i_sa  in  NB_ADDR  shamt field
i_flush  in  1  abort in-flight op
o_valid  out  1  one-cycle result strobe
o_result  out  NB_DATA  result, held until next completion
o_zero  out  1  o_result == 0, registered with o_result
o_alu_opcode  out  NB_ALU_OPCODE  opcode of last accepted op

Behaviour:
- Clock and reset: single clock i_clock. i_reset is synchronous, active-low. Reset: state IDLE, o_valid=0, o_result=0, o_zero=1, o_alu_opcode=0, count/work regs=0.
- Decode:
  - i_operation 01 -> 1000 (ADD).
  - i_operation 10 -> 1011 (SUB).
  - i_operation 00/11 -> i_ctrl_opcode[3:0].
- Opcode table:
  - 1000 ADD a+b; 1011 SUB a-b.
  - 1100 AND; 1101 OR; 1110 XOR; 0111 NOR.
  - 1001 SLT (signed a<b -> 1 else 0); 1111 LUI (b<<16).
  - 0000 SLL, 0010 SRL, 0011 SRA: value b, amount i_sa.
  - 1010 SLLV, 0110 SRLV, 0001 SRAV: value b, amount a[NB_ADDR-1:0].
  - Any other code -> result 0, single-cycle.
- Arithmetic: mod 2^NB_DATA, wraps silently. SRA/SRAV replicate b[NB_DATA-1].
- States:
  - IDLE: o_ready=1. A request is accepted on i_valid & o_ready.
  - SHIFT: o_ready=0.
- Accept in IDLE:
  - o_alu_opcode is latched.
  - Non-shift op, or shift with amount 0: o_result/o_zero updated and o_valid=1 on the accept edge. Latency 1; stays IDLE; back-to-back accepts allowed every cycle.
  - Shift with amount>0: latch work=value, cnt=amount; go to SHIFT; o_valid=0.
- SHIFT, each edge:
  - s=min(SHIFT_STEP,cnt); work shifted by s in the latched direction/type; cnt-=s.
  - When cnt<=SHIFT_STEP: o_result=final work, o_valid=1, go to IDLE.
  - Total latency = 1+ceil(amount/SHIFT_STEP) edges, accept edge included.
- i_valid while o_ready=0: ignored. The upstream holds the request; no queueing.
- i_flush:
  - In SHIFT: go to IDLE next edge, no o_valid, o_result unchanged.
  - In IDLE: suppresses acceptance that cycle.
  - Flush has priority over completion in the same cycle.
- o_valid is a single-cycle pulse with no downstream backpressure. o_result is stable until the next completion.
- Reset mid-SHIFT: immediately IDLE with reset values; the in-flight op is lost.

Optional Feature:
- Macro: ALU_OVERFLOW_EN.
- Defined:
  - Adds output o_overflow (1 bit), registered with o_result.
  - Set when signed ADD/SUB overflows (operand signs equal for ADD, differing for SUB, result sign differs from a); 0 for all other ops.
  - Reset 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
1. Reset: hold i_reset=0 two cycles -> o_valid=0, o_result=0, o_zero=1, o_ready=1.
2. ADD: op=01, a=0x0000_0005, b=0xFFFF_FFFB -> o_valid one edge later, o_result=0, o_zero=1. Back-to-back SUB (op=10, a=7, b=3) next cycle -> o_result=4.
3. SRA: i_ctrl_opcode=000011, b=0x8000_0000, i_sa=4, SHIFT_STEP=1:
   - o_ready=0 for 4 cycles; o_valid at edge 5 after accept; o_result=0xF800_0000.
   - Repeat with SHIFT_STEP=3 -> done in 3 edges, same result.
4. SLLV: a=0x0000_0020 (amount 0), b=0x1234 -> single-cycle, o_result=0x1234. SLT: a=-1, b=1 -> o_result=1.
5. Flush mid-shift: SLL i_sa=10, assert i_flush at 3rd SHIFT cycle -> no o_valid, IDLE next edge, o_result keeps prior value. i_valid during SHIFT ignored.
6. ALU_OVERFLOW_EN: ADD 0x7FFF_FFFF+1 -> o_result=0x8000_0000, o_overflow=1. SUB 0x8000_0000-1 -> o_overflow=1. AND -> 0. Reset asserted mid-shift -> IDLE, o_valid never asserts.

Source files
------------

// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute-stage ALU sequencer.
// Decodes the control opcode and operation select into an ALU opcode.
// Single-cycle ops complete on the accept edge. Shifts are iterated
// SHIFT_STEP bits per cycle in the SHIFT state behind a ready/valid
// handshake, and i_flush can abort them.
// Optional feature macro: ALU_OVERFLOW_EN adds o_overflow, which flags
// signed ADD/SUB overflow.
module alu_seq_exec #(
    parameter int NB_DATA        = 32,
    parameter int NB_ADDR        = $clog2(NB_DATA),
    parameter int NB_CTRL_OPCODE = 6,
    parameter int NB_ALU_OPCODE  = 4,
    parameter int NB_ALU_OP_SEL  = 2,
    parameter int SHIFT_STEP     = 1
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [NB_CTRL_OPCODE-1:0] i_ctrl_opcode,
    input  logic [NB_ALU_OP_SEL-1:0]  i_operation,
    input  logic [NB_DATA-1:0]        i_data_a,
    input  logic [NB_DATA-1:0]        i_data_b,
    input  logic [NB_ADDR-1:0]        i_sa,
    input  logic                      i_flush,
    output logic                      o_valid,
    output logic [NB_DATA-1:0]        o_result,
    output logic                      o_zero,
    output logic [NB_ALU_OPCODE-1:0]  o_alu_opcode
`ifdef ALU_OVERFLOW_EN
    ,
    output logic                      o_overflow
`endif
);

    localparam logic [NB_ALU_OP_SEL-1:0] SEL_MEM    = NB_ALU_OP_SEL'(2'b01);
    localparam logic [NB_ALU_OP_SEL-1:0] SEL_BRANCH = NB_ALU_OP_SEL'(2'b10);

    localparam logic [NB_ALU_OPCODE-1:0] OP_SLL  = NB_ALU_OPCODE'(4'b0000);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SRAV = NB_ALU_OPCODE'(4'b0001);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SRL  = NB_ALU_OPCODE'(4'b0010);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SRA  = NB_ALU_OPCODE'(4'b0011);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SRLV = NB_ALU_OPCODE'(4'b0110);
    localparam logic [NB_ALU_OPCODE-1:0] OP_NOR  = NB_ALU_OPCODE'(4'b0111);
    localparam logic [NB_ALU_OPCODE-1:0] OP_ADD  = NB_ALU_OPCODE'(4'b1000);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SLT  = NB_ALU_OPCODE'(4'b1001);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SLLV = NB_ALU_OPCODE'(4'b1010);
    localparam logic [NB_ALU_OPCODE-1:0] OP_SUB  = NB_ALU_OPCODE'(4'b1011);
    localparam logic [NB_ALU_OPCODE-1:0] OP_AND  = NB_ALU_OPCODE'(4'b1100);
    localparam logic [NB_ALU_OPCODE-1:0] OP_OR   = NB_ALU_OPCODE'(4'b1101);
    localparam logic [NB_ALU_OPCODE-1:0] OP_XOR  = NB_ALU_OPCODE'(4'b1110);
    localparam logic [NB_ALU_OPCODE-1:0] OP_LUI  = NB_ALU_OPCODE'(4'b1111);

    localparam logic [1:0] SH_LL = 2'b00;
    localparam logic [1:0] SH_RL = 2'b01;
    localparam logic [1:0] SH_RA = 2'b10;

    localparam int                 LUI_SHIFT = 16;
    localparam logic [NB_ADDR-1:0] STEP_W    = NB_ADDR'(SHIFT_STEP);
    localparam logic [NB_DATA-1:0] ZERO_W    = {NB_DATA{1'b0}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                     state_r;
    state_t                     state_s;
    logic [NB_ALU_OPCODE-1:0]   alu_opcode_s;
    logic                       is_shift_s;
    logic [1:0]                 sh_type_s;
    logic [NB_ADDR-1:0]         sh_amt_s;
    logic                       slt_s;
    logic [NB_DATA-1:0]         single_s;
    logic [NB_ADDR-1:0]         step_s;
    logic                       done_s;
    logic [NB_DATA-1:0]         shifted_s;
    logic                       accept_s;
    logic                       start_shift_s;
    logic                       fin_single_s;
    logic                       fin_shift_s;
    logic [NB_DATA-1:0]         work_r;
    logic [NB_ADDR-1:0]         cnt_r;
    logic [1:0]                 sh_type_r;
    logic [NB_DATA-1:0]         result_r;
    logic                       zero_r;
    logic                       valid_r;
    logic [NB_ALU_OPCODE-1:0]   alu_opcode_r;
    logic                       unused_ctrl_s;

    // Upper control-opcode bits carry no ALU meaning in this block.
    assign unused_ctrl_s = ^i_ctrl_opcode[NB_CTRL_OPCODE-1:NB_ALU_OPCODE];

`ifdef ALU_OVERFLOW_EN
    logic ovf_s;
    logic ovf_r;

    // Signed overflow: ADD needs equal operand signs, SUB differing ones,
    // and in both cases the result sign must differ from a.
    function automatic logic add_sub_ovf(input logic is_sub, input logic a_msb,
                                         input logic b_msb, input logic r_msb);
        logic same_sign;
        same_sign = (a_msb == b_msb);
        return (is_sub ? !same_sign : same_sign) && (r_msb != a_msb);
    endfunction
`endif

    // Operation decode: loads/stores add, branches subtract, others use the opcode.
    always_comb begin
        alu_opcode_s = i_ctrl_opcode[NB_ALU_OPCODE-1:0];
        case (i_operation)
            SEL_MEM:    alu_opcode_s = OP_ADD;
            SEL_BRANCH: alu_opcode_s = OP_SUB;
            default:    alu_opcode_s = i_ctrl_opcode[NB_ALU_OPCODE-1:0];
        endcase
    end

    // Shift classification: type and amount source (shamt or a).
    always_comb begin
        is_shift_s = 1'b0;
        sh_type_s  = SH_LL;
        sh_amt_s   = i_sa;
        case (alu_opcode_s)
            OP_SLL:  begin is_shift_s = 1'b1; sh_type_s = SH_LL; sh_amt_s = i_sa; end
            OP_SRL:  begin is_shift_s = 1'b1; sh_type_s = SH_RL; sh_amt_s = i_sa; end
            OP_SRA:  begin is_shift_s = 1'b1; sh_type_s = SH_RA; sh_amt_s = i_sa; end
            OP_SLLV: begin is_shift_s = 1'b1; sh_type_s = SH_LL; sh_amt_s = i_data_a[NB_ADDR-1:0]; end
            OP_SRLV: begin is_shift_s = 1'b1; sh_type_s = SH_RL; sh_amt_s = i_data_a[NB_ADDR-1:0]; end
            OP_SRAV: begin is_shift_s = 1'b1; sh_type_s = SH_RA; sh_amt_s = i_data_a[NB_ADDR-1:0]; end
            default: begin is_shift_s = 1'b0; sh_type_s = SH_LL; sh_amt_s = i_sa; end
        endcase
    end

    // Single-cycle result; shifts only take this path with amount 0 (result b).
    always_comb begin
        slt_s    = ($signed(i_data_a) < $signed(i_data_b));
        single_s = ZERO_W;
        case (alu_opcode_s)
            OP_ADD:  single_s = i_data_a + i_data_b;
            OP_SUB:  single_s = i_data_a - i_data_b;
            OP_AND:  single_s = i_data_a & i_data_b;
            OP_OR:   single_s = i_data_a | i_data_b;
            OP_XOR:  single_s = i_data_a ^ i_data_b;
            OP_NOR:  single_s = ~(i_data_a | i_data_b);
            OP_SLT:  single_s = {{(NB_DATA-1){1'b0}}, slt_s};
            OP_LUI:  single_s = i_data_b << LUI_SHIFT;
            OP_SLL, OP_SRL, OP_SRA,
            OP_SLLV, OP_SRLV, OP_SRAV: single_s = i_data_b;
            default: single_s = ZERO_W;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    // Overflow flag for the single-cycle path.
    always_comb begin
        if ((alu_opcode_s == OP_ADD) || (alu_opcode_s == OP_SUB)) begin
            ovf_s = add_sub_ovf(alu_opcode_s == OP_SUB, i_data_a[NB_DATA-1],
                                i_data_b[NB_DATA-1], single_s[NB_DATA-1]);
        end else begin
            ovf_s = 1'b0;
        end
    end
`endif

    // One shift iteration: move by min(SHIFT_STEP, remaining count).
    always_comb begin
        done_s    = (cnt_r <= STEP_W);
        step_s    = done_s ? cnt_r : STEP_W;
        shifted_s = work_r;
        case (sh_type_r)
            SH_LL:   shifted_s = work_r << step_s;
            SH_RL:   shifted_s = work_r >> step_s;
            SH_RA:   shifted_s = $signed(work_r) >>> step_s;
            default: shifted_s = work_r;
        endcase
    end

    // FSM next state and per-cycle strobes; flush outranks completion.
    always_comb begin
        state_s       = state_r;
        accept_s      = 1'b0;
        start_shift_s = 1'b0;
        fin_single_s  = 1'b0;
        fin_shift_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_valid && !i_flush) begin
                    accept_s = 1'b1;
                    if (is_shift_s && (sh_amt_s != {NB_ADDR{1'b0}})) begin
                        start_shift_s = 1'b1;
                        state_s       = ST_SHIFT;
                    end else begin
                        fin_single_s = 1'b1;
                        state_s      = ST_IDLE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (i_flush) begin
                    state_s = ST_IDLE;
                end else if (done_s) begin
                    fin_shift_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: opcode latch, shift work/count, result and strobe.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            work_r       <= ZERO_W;
            cnt_r        <= {NB_ADDR{1'b0}};
            sh_type_r    <= SH_LL;
            result_r     <= ZERO_W;
            zero_r       <= 1'b1;
            valid_r      <= 1'b0;
            alu_opcode_r <= {NB_ALU_OPCODE{1'b0}};
        end else begin
            valid_r <= fin_single_s | fin_shift_s;
            if (accept_s) begin
                alu_opcode_r <= alu_opcode_s;
            end
            if (start_shift_s) begin
                work_r    <= i_data_b;
                cnt_r     <= sh_amt_s;
                sh_type_r <= sh_type_s;
            end else if ((state_r == ST_SHIFT) && !i_flush) begin
                work_r <= shifted_s;
                cnt_r  <= cnt_r - step_s;
            end
            if (fin_single_s) begin
                result_r <= single_s;
                zero_r   <= (single_s == ZERO_W);
            end else if (fin_shift_s) begin
                result_r <= shifted_s;
                zero_r   <= (shifted_s == ZERO_W);
            end
        end
    end

`ifdef ALU_OVERFLOW_EN
    // Overflow flag, updated with every completion; shifts never overflow.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            ovf_r <= 1'b0;
        end else if (fin_single_s) begin
            ovf_r <= ovf_s;
        end else if (fin_shift_s) begin
            ovf_r <= 1'b0;
        end
    end

    assign o_overflow = ovf_r;
`endif

    assign o_ready      = (state_r == ST_IDLE);
    assign o_valid      = valid_r;
    assign o_result     = result_r;
    assign o_zero       = zero_r;
    assign o_alu_opcode = alu_opcode_r;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Testbench for alu_seq_exec: two instances (SHIFT_STEP 1 and 3) share the
// stimulus; a transaction-level model predicts every output each cycle,
// and directed vectors pin results to hand-computed literals.
module tb_alu_seq_exec;

    localparam int STEP_A = 1;
    localparam int STEP_B = 3;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        flush;
    logic [1:0]  oper;
    logic [5:0]  ctrl;
    logic [31:0] da;
    logic [31:0] db;
    logic [4:0]  sa;

    logic [1:0]       rdy;
    logic [1:0]       ov;
    logic [1:0]       zr;
    logic [1:0][31:0] res;
    logic [1:0][3:0]  opc;
`ifdef ALU_OVERFLOW_EN
    logic [1:0]       ovf;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic chk_en;

    alu_seq_exec #(.SHIFT_STEP(STEP_A)) u_dut_a (
        .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .o_ready(rdy[0]),
        .i_ctrl_opcode(ctrl), .i_operation(oper), .i_data_a(da), .i_data_b(db),
        .i_sa(sa), .i_flush(flush), .o_valid(ov[0]), .o_result(res[0]),
        .o_zero(zr[0]), .o_alu_opcode(opc[0])
`ifdef ALU_OVERFLOW_EN
        , .o_overflow(ovf[0])
`endif
    );

    alu_seq_exec #(.SHIFT_STEP(STEP_B)) u_dut_b (
        .i_clock(clk), .i_reset(rst_n), .i_valid(valid), .o_ready(rdy[1]),
        .i_ctrl_opcode(ctrl), .i_operation(oper), .i_data_a(da), .i_data_b(db),
        .i_sa(sa), .i_flush(flush), .o_valid(ov[1]), .o_result(res[1]),
        .o_zero(zr[1]), .o_alu_opcode(opc[1])
`ifdef ALU_OVERFLOW_EN
        , .o_overflow(ovf[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference functions (spec rules) ----------------
    function automatic logic [3:0] ref_decode(input logic [1:0] op, input logic [5:0] c);
        if (op == 2'b01) return 4'b1000;
        if (op == 2'b10) return 4'b1011;
        return c[3:0];
    endfunction

    function automatic logic ref_is_shift(input logic [3:0] o);
        return (o == 4'b0000) || (o == 4'b0010) || (o == 4'b0011) ||
               (o == 4'b1010) || (o == 4'b0110) || (o == 4'b0001);
    endfunction

    function automatic int ref_amt(input logic [3:0] o, input logic [31:0] a, input logic [4:0] s);
        if ((o == 4'b0000) || (o == 4'b0010) || (o == 4'b0011)) return int'(s);
        if ((o == 4'b1010) || (o == 4'b0110) || (o == 4'b0001)) return int'(a[4:0]);
        return 0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input int amt);
        logic [31:0] r;
        case (o)
            4'b1000: r = a + b;
            4'b1011: r = a - b;
            4'b1100: r = a & b;
            4'b1101: r = a | b;
            4'b1110: r = a ^ b;
            4'b0111: r = ~(a | b);
            4'b1001: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1111: r = {b[15:0], 16'h0000};
            4'b0000, 4'b1010: r = b << amt;
            4'b0010, 4'b0110: r = b >> amt;
            4'b0011, 4'b0001: r = $signed(b) >>> amt;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [3:0] o, input logic [31:0] a,
                                     input logic [31:0] b, input logic [31:0] r);
        if (o == 4'b1000) return (a[31] == b[31]) && (r[31] != a[31]);
        if (o == 4'b1011) return (a[31] != b[31]) && (r[31] != a[31]);
        return 1'b0;
    endfunction

    logic [3:0]  d_op;
    logic        d_shift;
    int          d_amt;
    logic [31:0] d_res;
    logic        d_ovf;

    // Request as seen by the model this cycle.
    always_comb begin
        d_op    = ref_decode(oper, ctrl);
        d_shift = ref_is_shift(d_op);
        d_amt   = ref_amt(d_op, da, sa);
        d_res   = ref_alu(d_op, da, db, d_amt);
        d_ovf   = ref_ovf(d_op, da, db, d_res);
    end

    // ---------------- transaction-level model, one per instance ----------------
    logic [1:0]       m_busy;
    logic [1:0]       m_valid;
    logic [1:0]       m_ovf;
    logic [1:0][31:0] m_result;
    logic [1:0][3:0]  m_opc;

    for (genvar k = 0; k < 2; k++) begin : g_model
        localparam int STEP = (k == 0) ? STEP_A : STEP_B;
        logic        busy_q, valid_q, ovf_q;
        logic [31:0] result_q, pend_q;
        logic [3:0]  opc_q;
        int          rem_q;

        // Busy for ceil(amount/STEP) edges after a shift accept.
        always @(posedge clk) begin
            if (!rst_n) begin
                busy_q <= 1'b0; valid_q <= 1'b0; ovf_q <= 1'b0;
                result_q <= 32'd0; opc_q <= 4'd0; rem_q <= 0;
            end else if (!busy_q) begin
                if (valid && !flush) begin
                    opc_q <= d_op;
                    if (d_shift && (d_amt != 0)) begin
                        busy_q  <= 1'b1;
                        rem_q   <= (d_amt + STEP - 1) / STEP;
                        pend_q  <= d_res;
                        valid_q <= 1'b0;
                    end else begin
                        valid_q  <= 1'b1;
                        result_q <= d_res;
                        ovf_q    <= d_ovf;
                    end
                end else begin
                    valid_q <= 1'b0;
                end
            end else if (flush) begin
                busy_q  <= 1'b0;
                valid_q <= 1'b0;
            end else if (rem_q == 1) begin
                busy_q   <= 1'b0;
                valid_q  <= 1'b1;
                result_q <= pend_q;
                ovf_q    <= 1'b0;
            end else begin
                rem_q   <= rem_q - 1;
                valid_q <= 1'b0;
            end
        end

        assign m_busy[k]   = busy_q;
        assign m_valid[k]  = valid_q;
        assign m_ovf[k]    = ovf_q;
        assign m_result[k] = result_q;
        assign m_opc[k]    = opc_q;
    end

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got 0x%08h, expected 0x%08h", name, k, act, exp);
        end
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                chk("ready",  k, 32'(rdy[k]), 32'(!m_busy[k]));
                chk("valid",  k, 32'(ov[k]),  32'(m_valid[k]));
                chk("result", k, res[k],      m_result[k]);
                chk("zero",   k, 32'(zr[k]),  32'(m_result[k] == 32'd0));
                chk("opcode", k, 32'(opc[k]), 32'(m_opc[k]));
`ifdef ALU_OVERFLOW_EN
                chk("overflow", k, 32'(ovf[k]), 32'(m_ovf[k]));
`endif
            end
        end
    end

    // One-cycle request; returns 1 time unit after the accept edge.
    task automatic drive(input logic [1:0] op, input logic [5:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] s);
        valid = 1'b1; oper = op; ctrl = c; da = a; db = b; sa = s;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    // Issue a request and check each instance's result against a literal.
    task automatic run(input string name, input logic [1:0] op, input logic [5:0] c,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] s,
                       input logic [31:0] exp);
        logic [1:0] seen;
        seen = 2'b00;
        drive(op, c, a, b, s);
        for (int e = 0; (e < 40) && (seen != 2'b11); e++) begin
            for (int k = 0; k < 2; k++) begin
                if (ov[k] && !seen[k]) begin
                    seen[k] = 1'b1;
                    chk(name, k, res[k], exp);
                end
            end
            if (seen != 2'b11) begin
                @(posedge clk); #1;
            end
        end
        for (int k = 0; k < 2; k++) chk({name, "_done"}, k, 32'(seen[k]), 32'd1);
    endtask

    initial begin
        int t_a, t_b;
        logic [31:0] r_a, r_b;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_a, t_b;
        logic [31:0] r_a, r_b;
        chk_en = 1'b0;
        rst_n = 1'b0; valid = 1'b0; flush = 1'b0;
        oper = 2'b00; ctrl = 6'd0; da = 32'd0; db = 32'd0; sa = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid",  k, 32'(ov[k]),  32'd0);
            chk("rst_result", k, res[k],      32'd0);
            chk("rst_zero",   k, 32'(zr[k]),  32'd1);
            chk("rst_ready",  k, 32'(rdy[k]), 32'd1);
            chk("rst_opcode", k, 32'(opc[k]), 32'd0);
        end
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // ADD then back-to-back SUB
        run("add_zero", 2'b01, 6'b000000, 32'h0000_0005, 32'hFFFF_FFFB, 5'd0, 32'h0000_0000);
        for (int k = 0; k < 2; k++) chk("add_zero_flag", k, 32'(zr[k]), 32'd1);
        run("sub_b2b",  2'b10, 6'b000000, 32'd7, 32'd3, 5'd0, 32'd4);
        for (int k = 0; k < 2; k++) chk("sub_opcode", k, 32'(opc[k]), 32'hB);

        // single-cycle directed vectors
        run("and",      2'b00, 6'b001100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'h00F0_00F0);
        run("or",       2'b11, 6'b001101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'hFFF0_FFF0);
        run("xor",      2'b00, 6'b001110, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 32'hFF00_FF00);
        run("nor",      2'b00, 6'b000111, 32'h0000_0000, 32'h0000_0000, 5'd0, 32'hFFFF_FFFF);
        run("slt_neg",  2'b00, 6'b001001, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 32'h0000_0001);
        run("slt_pos",  2'b00, 6'b001001, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000);
        run("lui",      2'b00, 6'b001111, 32'h0000_0000, 32'h0000_ABCD, 5'd0, 32'hABCD_0000);
        run("undef4",   2'b00, 6'b000100, 32'd5, 32'd6, 5'd0, 32'h0000_0000);
        run("undef5",   2'b11, 6'b000101, 32'd5, 32'd6, 5'd0, 32'h0000_0000);
        run("sllv_z",   2'b00, 6'b001010, 32'h0000_0020, 32'h0000_1234, 5'd0, 32'h0000_1234);
        run("add_wrap", 2'b11, 6'b101000, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0, 32'h0000_0001);
        run("br_sub",   2'b10, 6'b001100, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE);
        run("mem_add",  2'b01, 6'b000000, 32'd10, 32'd20, 5'd0, 32'h0000_001E);

        // SRA by 4: latency 5 edges with step 1, 3 edges with step 3
        drive(2'b00, 6'b000011, 32'd0, 32'h8000_0000, 5'd4);
        t_a = 0; t_b = 0; r_a = 32'd0; r_b = 32'd0;
        for (int e = 1; e <= 12; e++) begin
            if (ov[0] && (t_a == 0)) begin t_a = e; r_a = res[0]; end
            if (ov[1] && (t_b == 0)) begin t_b = e; r_b = res[1]; end
            if ((t_a != 0) && (t_b != 0)) break;
            @(posedge clk); #1;
        end
        chk("sra_lat", 0, 32'(t_a), 32'd5);
        chk("sra_lat", 1, 32'(t_b), 32'd3);
        chk("sra_res", 0, r_a, 32'hF800_0000);
        chk("sra_res", 1, r_b, 32'hF800_0000);

        // iterative shifts
        run("srl31",  2'b00, 6'b000010, 32'd0, 32'h8000_0000, 5'd31, 32'h0000_0001);
        run("srav4",  2'b00, 6'b000001, 32'h0000_0024, 32'h8000_0000, 5'd0, 32'hF800_0000);
        run("srlv8",  2'b00, 6'b000110, 32'h0000_0008, 32'hFF00_0000, 5'd0, 32'h00FF_0000);
        run("sra_p5", 2'b00, 6'b000011, 32'd0, 32'h4000_0000, 5'd5, 32'h0200_0000);
        run("sll3",   2'b00, 6'b000000, 32'd0, 32'h0000_0001, 5'd3, 32'h0000_0008);

        // flush in the 3rd SHIFT cycle, with a held request ignored meanwhile
        drive(2'b00, 6'b000000, 32'd0, 32'h0000_0001, 5'd10);
        valid = 1'b1; oper = 2'b01; da = 32'd1; db = 32'd1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("flush_ready",  k, 32'(rdy[k]), 32'd1);
            chk("flush_valid",  k, 32'(ov[k]),  32'd0);
            chk("flush_result", k, res[k],      32'h0000_0008);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) chk("flush_novalid", k, 32'(ov[k]), 32'd0);

        // flush in IDLE suppresses acceptance
        valid = 1'b1; flush = 1'b1; oper = 2'b01; da = 32'd2; db = 32'd3;
        @(posedge clk); #1;
        valid = 1'b0; flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("idle_flush_valid",  k, 32'(ov[k]),  32'd0);
            chk("idle_flush_opcode", k, 32'(opc[k]), 32'd0);
            chk("idle_flush_result", k, res[k],      32'h0000_0008);
        end

`ifdef ALU_OVERFLOW_EN
        run("ovf_add", 2'b01, 6'b000000, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 32'h8000_0000);
        for (int k = 0; k < 2; k++) chk("ovf_add_flag", k, 32'(ovf[k]), 32'd1);
        run("ovf_sub", 2'b10, 6'b000000, 32'h8000_0000, 32'h0000_0001, 5'd0, 32'h7FFF_FFFF);
        for (int k = 0; k < 2; k++) chk("ovf_sub_flag", k, 32'(ovf[k]), 32'd1);
        run("ovf_and", 2'b00, 6'b001100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'hFFFF_FFFF);
        for (int k = 0; k < 2; k++) chk("ovf_and_flag", k, 32'(ovf[k]), 32'd0);
`endif

        // reset mid-shift: in-flight op lost, no result ever
        drive(2'b00, 6'b000000, 32'd0, 32'h0000_0001, 5'd20);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            chk("mid_rst_result", k, res[k],      32'd0);
            chk("mid_rst_zero",   k, 32'(zr[k]),  32'd1);
            chk("mid_rst_ready",  k, 32'(rdy[k]), 32'd1);
            chk("mid_rst_opcode", k, 32'(opc[k]), 32'd0);
        end
        for (int e = 0; e < 25; e++) begin
            for (int k = 0; k < 2; k++) chk("mid_rst_novalid", k, 32'(ov[k]), 32'd0);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
